// File: rtl/bus_if_ext.sv
// CPU-side bus interface for one pipeline stage (IF or MEM).
// Scratch-pad hits complete combinationally in the issuing cycle.
// All other slaves use a request/grant/access/ready handshake.
// That handshake has an optional timeout and a read buffer that is held during stall.
module bus_if_ext #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3,
  parameter int SPM_IDX = 1,
  parameter int TMO_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                as_,
  input  logic                rw,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                err,
  output logic [ADDR_W-1:0]   spm_addr,
  output logic                spm_as_,
  output logic                spm_rw,
  output logic [DATA_W/8-1:0] spm_be,
  output logic [DATA_W-1:0]   spm_wr_data,
  input  logic [DATA_W-1:0]   spm_rd_data,
  output logic                bus_req_,
  input  logic                bus_grnt_,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_as_,
  output logic                bus_rw,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wr_data,
  input  logic [DATA_W-1:0]   bus_rd_data,
  input  logic                bus_rdy_
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] STALL  = 2'd3;

  localparam logic READ  = 1'b1;
  localparam bit   TMO_EN = (TMO_CYC > 0);
  localparam int   TMO_W  = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

  logic [1:0]          state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_as_q, bus_as_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic                bus_rw_q, bus_rw_d;
  logic [DATA_W/8-1:0] bus_be_q, bus_be_d;
  logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
  logic                buf_rd_q, buf_rd_d;   // finished transfer was a read: STALL shows rd_buf
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;

  logic                access, hit, complete, abort;
  logic [DATA_W-1:0]   rd_data_c;
  logic                busy_c, spm_as_c;

  // Next-state and combinational CPU-side outputs
  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_addr_d    = bus_addr_q;
    bus_rw_d      = bus_rw_q;
    bus_be_d      = bus_be_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    buf_rd_d      = buf_rd_q;
    tmo_d         = tmo_q;
    err_d         = 1'b0;
    rd_data_c     = '0;
    busy_c        = 1'b0;
    spm_as_c      = 1'b1;

    access   = !as_ && !flush;
    hit      = (addr[ADDR_W-1 -: IDX_W] == IDX_W'(SPM_IDX));
    complete = (state_q == ACCESS) && !bus_rdy_;
    // A ready in the last allowed cycle takes priority over the abort.
    abort    = TMO_EN && ((state_q == REQ) || (state_q == ACCESS)) &&
               (tmo_q == TMO_LAST) && !complete;

    case (state_q)
      IDLE: begin
        if (access && hit && !stall) begin
          spm_as_c = 1'b0;
          if (rw == READ) rd_data_c = spm_rd_data;
        end else if (access && !hit) begin
          busy_c        = 1'b1;
          bus_addr_d    = addr;
          bus_rw_d      = rw;
          bus_be_d      = be;
          bus_wr_data_d = wr_data;
          bus_req_d     = 1'b0;
          tmo_d         = '0;
          state_d       = REQ;
        end
      end
      REQ: begin
        busy_c = 1'b1;
        tmo_d  = tmo_q + 1'b1;
        if (!bus_grnt_) begin
          bus_as_d = 1'b0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        bus_as_d = 1'b1;
        tmo_d    = tmo_q + 1'b1;
        if (bus_rdy_) begin
          busy_c = 1'b1;
        end else if (bus_rw_q == READ) begin
          rd_data_c = bus_rd_data;
        end
      end
      default: begin  // STALL
        if (buf_rd_q) rd_data_c = rd_buf_q;
        if (!stall) state_d = IDLE;
      end
    endcase

    // Completion and abort both release the bus the same way.
    // An aborted read returns zero data.
    if (complete || abort) begin
      bus_req_d     = 1'b1;
      bus_as_d      = 1'b1;
      bus_addr_d    = '0;
      bus_rw_d      = READ;
      bus_be_d      = '0;
      bus_wr_data_d = '0;
      buf_rd_d      = (bus_rw_q == READ);
      if (abort)                  rd_buf_d = '0;
      else if (bus_rw_q == READ)  rd_buf_d = bus_rd_data;
      err_d   = abort;
      state_d = stall ? STALL : IDLE;
    end
  end

  // Registered state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_rw_q      <= READ;
      bus_be_q      <= '0;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
      buf_rd_q      <= 1'b0;
      tmo_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_addr_q    <= bus_addr_d;
      bus_rw_q      <= bus_rw_d;
      bus_be_q      <= bus_be_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
      buf_rd_q      <= buf_rd_d;
      tmo_q         <= tmo_d;
      err_q         <= err_d;
    end
  end

  // While reset is held, the combinational outputs are forced to their idle values.
  assign rd_data     = reset ? '0   : rd_data_c;
  assign busy        = reset ? 1'b0 : busy_c;
  assign spm_as_     = reset ? 1'b1 : spm_as_c;
  assign err         = err_q;

  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_be      = be;
  assign spm_wr_data = wr_data;

  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_addr    = bus_addr_q;
  assign bus_rw      = bus_rw_q;
  assign bus_be      = bus_be_q;
  assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_bus_if_ext.sv
// Directed bench for bus_if_ext.
// It covers SPM hits, bus write and read, read-buffer hold, timeout, flush, and reset mid-access.
module tb_bus_if_ext;

  logic        clk = 1'b0;
  logic        reset, stall, flush, as_, rw;
  logic [29:0] addr;
  logic [3:0]  be;
  logic [31:0] wr_data, rd_data, spm_rd_data, bus_rd_data, spm_wr_data, bus_wr_data;
  logic        busy, err, spm_as_, spm_rw, bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [29:0] spm_addr, bus_addr;
  logic [3:0]  spm_be, bus_be;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt, as_cnt, buf_cnt, err_cnt;

  bus_if_ext #(.ADDR_W(30), .DATA_W(32), .IDX_W(3), .SPM_IDX(1), .TMO_CYC(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .addr(addr), .as_(as_),
    .rw(rw), .be(be), .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .err(err),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_be(spm_be),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_be(bus_be), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
    addr = '0; be = '0; wr_data = '0; spm_rd_data = '0; bus_rd_data = '0;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    tick(); tick();

    // Reset state, sampled with reset still asserted
    check_eq("rst busy", busy, 0);
    check_eq("rst spm_as_", spm_as_, 1);
    check_eq("rst rd_data", rd_data, 0);
    check_eq("rst bus_req_", bus_req_, 1);
    check_eq("rst bus_as_", bus_as_, 1);
    check_eq("rst bus_addr", bus_addr, 0);
    check_eq("rst bus_rw", bus_rw, 1);
    check_eq("rst bus_be", bus_be, 0);
    check_eq("rst err", err, 0);
    reset = 1'b0;
    tick();

    // SPM read: index 1, zero latency
    addr = 30'h0800_0010; as_ = 1'b0; rw = 1'b1; spm_rd_data = 32'hDEAD_BEEF;
    #1;
    check_eq("spm spm_as_", spm_as_, 0);
    check_eq("spm rd_data", rd_data, 32'hDEAD_BEEF);
    check_eq("spm busy", busy, 0);
    tick();
    check_eq("spm bus_req_", bus_req_, 1);
    $display("txn spm_read addr=%h rd=%h", addr, rd_data);
    as_ = 1'b1;
    tick();

    // Bus write, index 2: grant after 2 REQ cycles, ready on the 3rd ACCESS cycle
    busy_cnt = 0; as_cnt = 0; err_cnt = 0;
    addr = 30'h1000_0123; rw = 1'b0; be = 4'b0011; wr_data = 32'h1234_5678; as_ = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      bus_grnt_ = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      bus_rdy_  = (c == 6) ? 1'b0 : 1'b1;
      if (c >= 6) as_ = 1'b1;
      #1;
      if (busy) busy_cnt++;
      if (!bus_as_) as_cnt++;
      if (err) err_cnt++;
      if (c == 1) begin
        check_eq("wr bus_be", bus_be, 4'b0011);
        check_eq("wr bus_wr_data", bus_wr_data, 32'h1234_5678);
        check_eq("wr bus_addr", bus_addr, 30'h1000_0123);
        check_eq("wr bus_rw", bus_rw, 0);
      end
      if (c == 6) check_eq("wr bus_req_ at ready", bus_req_, 0);
      if (c == 7) begin
        check_eq("wr bus_req_ after ready", bus_req_, 1);
        check_eq("wr bus_be cleared", bus_be, 0);
      end
      tick();
    end
    check_eq("wr busy cycles", busy_cnt, 6);
    check_eq("wr bus_as_ low cycles", as_cnt, 1);
    check_eq("wr err count", err_cnt, 0);
    $display("txn bus_write addr=1000_0123 busy_cycles=%0d as_cycles=%0d", busy_cnt, as_cnt);

    // Bus read, index 3: immediate grant, ready in the first ACCESS cycle, stall held 4 cycles past ready
    buf_cnt = 0; busy_cnt = 0;
    addr = 30'h1800_0040; rw = 1'b1; be = 4'b1111; as_ = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      bus_grnt_   = (c == 1) ? 1'b0 : 1'b1;
      bus_rdy_    = (c == 2) ? 1'b0 : 1'b1;
      bus_rd_data = (c == 2) ? 32'hCAFE_0001 : 32'h5555_AAAA;
      stall       = (c >= 2 && c <= 6) ? 1'b1 : 1'b0;
      if (c >= 1) as_ = 1'b1;
      #1;
      if (c == 2) begin
        check_eq("rd rd_data at ready", rd_data, 32'hCAFE_0001);
        check_eq("rd busy at ready", busy, 0);
      end
      if (c >= 3 && c <= 7 && rd_data == 32'hCAFE_0001) buf_cnt++;
      if (c >= 3 && busy) busy_cnt++;
      if (c == 8) check_eq("rd rd_data back in idle", rd_data, 0);
      tick();
    end
    check_eq("rd held cycles", buf_cnt, 5);
    check_eq("rd busy during stall", busy_cnt, 0);
    $display("txn bus_read addr=1800_0040 data=cafe0001 held=%0d", buf_cnt);

    // Timeout: index 5 read, grant never comes, stall held over the abort
    busy_cnt = 0;
    addr = 30'h2800_0004; rw = 1'b1; as_ = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      if (c >= 1) as_ = 1'b1;
      stall = (c == 8 || c == 9) ? 1'b1 : 1'b0;
      #1;
      if (c >= 1 && busy) busy_cnt++;
      if (c == 8) check_eq("tmo bus_req_ last cycle", bus_req_, 0);
      if (c == 9) begin
        check_eq("tmo err pulse", err, 1);
        check_eq("tmo bus_req_ released", bus_req_, 1);
        check_eq("tmo rd_data zero", rd_data, 0);
      end
      if (c == 10) check_eq("tmo err one cycle", err, 0);
      tick();
    end
    check_eq("tmo busy cycles", busy_cnt, 8);
    $display("txn timeout addr=2800_0004 busy_cycles=%0d", busy_cnt);

    // Flush in IDLE on a bus slave: nothing issued
    addr = 30'h1000_0008; as_ = 1'b0; flush = 1'b1;
    #1;
    check_eq("flush busy", busy, 0);
    tick();
    check_eq("flush bus_req_", bus_req_, 1);
    tick();
    check_eq("flush bus_req_ later", bus_req_, 1);
    flush = 1'b0; as_ = 1'b1;
    $display("txn flush addr=1000_0008 req=%0b", bus_req_);
    tick();

    // Reset while in ACCESS
    addr = 30'h1000_0100; rw = 1'b0; be = 4'b1100; wr_data = 32'hA5A5_5A5A; as_ = 1'b0;
    tick();
    as_ = 1'b1; bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    #1;
    check_eq("rstx in access bus_as_", bus_as_, 0);
    reset = 1'b1;
    #1;
    check_eq("rstx busy", busy, 0);
    tick();
    check_eq("rstx bus_req_", bus_req_, 1);
    check_eq("rstx bus_as_", bus_as_, 1);
    check_eq("rstx bus_addr", bus_addr, 0);
    check_eq("rstx bus_be", bus_be, 0);
    check_eq("rstx bus_wr_data", bus_wr_data, 0);
    check_eq("rstx err", err, 0);
    reset = 1'b0;
    tick();
    check_eq("rstx err after", err, 0);
    $display("txn reset_in_access req=%0b as=%0b", bus_req_, bus_as_);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
